// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with 16x oversampling from a phase
// accumulator, start-bit validation, stop-bit check and a 1-deep output
// register with a valid/ack handshake.
// Optional build macro UART_RX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit, plus a PARITY_ERR pulse output.
//
// Handshake: RX_VALID is high while RX_DATA holds a byte the consumer has not
// acknowledged. A one-cycle RX_ACK while RX_VALID is high clears RX_VALID on
// the next clock; RX_ACK while RX_VALID is low has no effect. A new good byte
// completing in the same cycle as RX_ACK wins: RX_VALID stays high with the
// new data. A new byte completing while RX_VALID is high and RX_ACK is low
// overwrites RX_DATA and sets the sticky OVERRUN flag.
module uart_rx_byte #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 9600,
   parameter int ACC_WIDTH = 16,
   parameter int ACC_INC   = int'((64'(BAUD) * 64'd16 * (64'd1 << ACC_WIDTH)
                                  + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ))
) (
   input  logic       CLK_50,
   input  logic       RESET,
   input  logic       RxD,
   input  logic       RX_ACK,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       RX_BUSY,
   output logic       FRAME_ERR,
   output logic       OVERRUN,
`ifdef UART_RX_PARITY_EN
   output logic       PARITY_ERR,
`endif
   output logic [2:0] o_dbg_state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
   localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd5;
`endif

   localparam logic [ACC_WIDTH:0] W_INC = (ACC_WIDTH + 1)'(ACC_INC);

   logic [ACC_WIDTH:0] r_acc;
   logic               r_sync1;
   logic               r_sync2;
   logic [2:0]         r_state;
   logic [3:0]         r_cnt;
   logic [2:0]         r_bit;
   logic [7:0]         r_shift;
   logic [7:0]         r_data;
   logic               r_valid;
   logic               r_ferr;
   logic               r_ovr;
`ifdef UART_RX_PARITY_EN
   logic               r_par_bad;
   logic               r_perr;
`endif

   logic               w_tick;
   logic               w_rxs;
   logic               w_stop_smp;
   logic               w_good;

   assign w_tick     = r_acc[ACC_WIDTH];
   assign w_rxs      = r_sync2;
   assign w_stop_smp = (r_state == S_STOP) && w_tick && (r_cnt == 4'd15);
`ifdef UART_RX_PARITY_EN
   assign w_good     = w_stop_smp && w_rxs && !r_par_bad;
`else
   assign w_good     = w_stop_smp && w_rxs;
`endif

   // Free-running phase accumulator; its carry is the 16x oversample tick.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         r_acc <= '0;
      end else begin
         r_acc <= {1'b0, r_acc[ACC_WIDTH-1:0]} + W_INC;
      end
   end

   // Two-flop synchronizer on the asynchronous line; resets to idle-high.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RxD;
         r_sync2 <= r_sync1;
      end
   end

   // Frame sequencer: start validation at mid start bit, then one sample per
   // 16 ticks for data, (parity,) stop; a low stop parks in BREAK until the
   // line goes high so a held-low line cannot retrigger.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_bit     <= 3'd0;
         r_shift   <= 8'h00;
         r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad <= 1'b0;
         r_perr    <= 1'b0;
`endif
      end else begin
         r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_perr <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_tick && !w_rxs) begin
                  r_cnt   <= 4'd0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_tick) begin
                  if (r_cnt == 4'd7) begin
                     if (w_rxs) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_cnt   <= 4'd0;
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                     end
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == 4'd15) begin
                     r_shift <= {w_rxs, r_shift[7:1]};
                     r_bit   <= r_bit + 3'd1;
                     if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= S_PARITY;
`else
                        r_state <= S_STOP;
`endif
                     end
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_tick) begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == 4'd15) begin
                     r_par_bad <= w_rxs ^ (^r_shift);
                     r_state   <= S_STOP;
                  end
               end
            end
`endif
            S_STOP: begin
               if (w_tick) begin
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == 4'd15) begin
`ifdef UART_RX_PARITY_EN
                     r_perr <= r_par_bad;
`endif
                     if (w_rxs) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_ferr  <= 1'b1;
                        r_state <= S_BREAK;
                     end
                  end
               end
            end
            S_BREAK: begin
               if (w_rxs) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Output holding register and handshake; a completing byte beats RX_ACK.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (w_good) begin
         r_data  <= r_shift;
         r_valid <= 1'b1;
         if (r_valid && !RX_ACK) begin
            r_ovr <= 1'b1;
         end
      end else if (RX_ACK) begin
         r_valid <= 1'b0;
      end
   end

   assign RX_DATA     = r_data;
   assign RX_VALID    = r_valid;
   assign RX_BUSY     = (r_state != S_IDLE);
   assign FRAME_ERR   = r_ferr;
   assign OVERRUN     = r_ovr;
`ifdef UART_RX_PARITY_EN
   assign PARITY_ERR  = r_perr;
`endif
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte. Runs the receiver at 64 clocks per bit (tick every
// 4 clocks) so every frame fits in a few hundred cycles. A line-level model
// predicts all outputs on every clock from the recorded RxD history.
module tb_uart_rx_byte;
  localparam int BIT_CLKS = 64;
  localparam int MAX_EDGES = 65535;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  uart_rx_byte #(
    .CLK_FREQ(50000000),
    .BAUD(781250)
  ) dut (
    .CLK_50(clk),
    .RESET(rst),
    .RxD(rxd),
    .RX_ACK(ack),
    .RX_DATA(rx_data),
    .RX_VALID(rx_valid),
    .RX_BUSY(rx_busy),
    .FRAME_ERR(frame_err),
    .OVERRUN(overrun),
    .o_dbg_state(dbg_state)
  );

  // ---------------- counters / checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural line model ----------------
  int         g = 0;       // posedge index
  int         g_rst = 0;   // last posedge with RESET high
  int         md = 0;      // 0 idle, 1 inside a frame, 2 waiting for line high
  int         m0 = 0;      // posedge on which the start edge was seen on a tick
  logic       line_h [0:MAX_EDGES];
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ovr = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_busy = 1'b0;
  logic       armed = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         dut_ferr_cnt = 0;
  int         dut_vrise = 0;
  logic       prev_valid = 1'b0;

  always @(posedge clk) begin : model_p
    logic       rxs, tk, good, ack_s;
    logic [7:0] b;
    int         k;
    g = g + 1;
    if (g <= MAX_EDGES) line_h[g] = rxd;
    ack_s = ack;
    good = 1'b0;
    exp_ferr = 1'b0;
    b = 8'h00;
    if (rst) begin
      g_rst = g; md = 0;
      exp_data = 8'h00; exp_valid = 1'b0; exp_ovr = 1'b0;
      armed = 1'b1;
    end else begin
      // ticks land every 4th clock, the first one 5 clocks after reset;
      // decisions see RxD as it was two clocks earlier
      k = g - g_rst;
      tk = (k >= 5) && (k % 4 == 1);
      rxs = (g - 2 <= g_rst) ? 1'b1 : line_h[g-2];
      case (md)
        0: if (tk && !rxs) begin md = 1; m0 = g; end
        1: begin
          if (g == m0 + 32) begin
            if (rxs) md = 0;
          end else if (g == m0 + 32 + 9 * BIT_CLKS) begin
            for (int i = 0; i < 8; i++) b[i] = line_h[m0 + 30 + BIT_CLKS * (i + 1)];
            if (rxs) begin good = 1'b1; md = 0; end
            else begin exp_ferr = 1'b1; md = 2; end
          end
        end
        2: if (rxs) md = 0;
        default: md = 0;
      endcase
      if (good) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_spurious: got byte %0h expected none", b);
        end else begin
          chk("sb_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
        if (exp_valid && !ack_s) exp_ovr = 1'b1;
        exp_data = b;
        exp_valid = 1'b1;
      end else if (ack_s) begin
        exp_valid = 1'b0;
      end
    end
    exp_busy = (md != 0);
    #1;
    if (armed) begin
      chk("rx_data", {24'd0, rx_data}, {24'd0, exp_data});
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid});
      chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
      chk("rx_busy", {31'd0, rx_busy}, {31'd0, exp_busy});
      if (frame_err === 1'b1) dut_ferr_cnt++;
      if (rx_valid === 1'b1 && !prev_valid) begin
        dut_vrise++;
        got_q.push_back(rx_data);
      end
      prev_valid = (rx_valid === 1'b1);
    end
  end

  // ---------------- ack driver ----------------
  // 0: never, 1: random pulses, 2: exactly on the frame's stop sample, 3: at ack_edge
  int ack_mode = 0;
  int ack_edge = 0;
  always @(negedge clk) begin
    case (ack_mode)
      1: ack = ($urandom_range(0, 3) == 0);
      2: ack = (md == 1) && (g + 1 == m0 + 32 + 9 * BIT_CLKS);
      3: ack = (g + 1 == ack_edge);
      default: ack = 1'b0;
    endcase
  end

  // ---------------- line driver tasks ----------------
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    if (stop_ok) exp_q.push_back(d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_ok);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(10 * 60000);
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    report();
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin : main_p
    int f0, v0;
    logic [7:0] bytes4 [4];
    logic [7:0] rb;
    int r;
    bytes4[0] = 8'h0A; bytes4[1] = 8'h4C; bytes4[2] = 8'h61; bytes4[3] = 8'h62;

    repeat (4) @(negedge clk);
    chk("rst_data", {24'd0, rx_data}, 32'h00);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    idle(50 + $urandom_range(0, 7));

    // single byte 'u', then ack clears valid one cycle later
    send_frame(8'h75, 1'b1);
    idle(20);
    chk("u_data", {24'd0, rx_data}, 32'h75);
    chk("u_valid", {31'd0, rx_valid}, 32'd1);
    chk("u_ferr_cnt", dut_ferr_cnt, 32'd0);
    chk("u_busy", {31'd0, rx_busy}, 32'd0);
    ack_edge = g + 2;
    ack_mode = 3;
    @(negedge clk);
    chk("u_valid_before_ack", {31'd0, rx_valid}, 32'd1);
    @(negedge clk);
    chk("u_ack_clears", {31'd0, rx_valid}, 32'd0);
    ack_mode = 0;
    idle(10);

    // four back-to-back bytes with acks (random acks also hit while idle)
    got_q.delete();
    ack_mode = 1;
    for (int i = 0; i < 4; i++) send_frame(bytes4[i], 1'b1);
    idle(100);
    chk("b2b_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk("b2b_byte", {24'd0, got_q[i]}, {24'd0, bytes4[i]});
    chk("b2b_ovr", {31'd0, overrun}, 32'd0);
    ack_mode = 0;

    // low glitch shorter than half a bit: false start
    f0 = dut_ferr_cnt; v0 = dut_vrise;
    rxd = 1'b0;
    repeat (24) @(negedge clk);
    idle(80);
    chk("glitch_vrise", dut_vrise, v0);
    chk("glitch_ferr", dut_ferr_cnt, f0);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd0);

    // 0x55 with low stop bit, line held low 3 more bit times
    f0 = dut_ferr_cnt; v0 = dut_vrise;
    send_frame(8'h55, 1'b0);
    rxd = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("break_busy", {31'd0, rx_busy}, 32'd1);
    idle(20);
    chk("break_ferr_cnt", dut_ferr_cnt, f0 + 1);
    chk("break_vrise", dut_vrise, v0);
    chk("break_busy_end", {31'd0, rx_busy}, 32'd0);

    // overrun: two bytes without ack
    send_frame(8'h41, 1'b1);
    send_frame(8'h42, 1'b1);
    idle(20);
    chk("ovr_data", {24'd0, rx_data}, 32'h42);
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);

    // same again after reset, ack coincident with second completion
    pulse_reset();
    idle(30);
    send_frame(8'h41, 1'b1);
    idle(10);
    ack_mode = 2;
    send_frame(8'h42, 1'b1);
    idle(20);
    ack_mode = 0;
    chk("coinc_data", {24'd0, rx_data}, 32'h42);
    chk("coinc_valid", {31'd0, rx_valid}, 32'd1);
    chk("coinc_ovr", {31'd0, overrun}, 32'd0);

    // reset mid-data of 0x7E, then a clean 0x7E
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    chk("midrst_data", {24'd0, rx_data}, 32'h00);
    chk("midrst_valid", {31'd0, rx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, rx_busy}, 32'd0);
    chk("midrst_ovr", {31'd0, overrun}, 32'd0);
    idle(100);
    send_frame(8'h7E, 1'b1);
    idle(20);
    chk("post_rst_data", {24'd0, rx_data}, 32'h7E);
    chk("post_rst_valid", {31'd0, rx_valid}, 32'd1);

    // randomized traffic
    ack_mode = 1;
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      rb = 8'($urandom_range(0, 255));
      if (r == 0) begin
        rxd = 1'b0;
        repeat ($urandom_range(1, 24)) @(negedge clk);
        idle(48 + $urandom_range(0, 20));
      end else if (r == 1) begin
        send_frame(rb, 1'b0);
        idle(BIT_CLKS + $urandom_range(0, 40));
      end else begin
        send_frame(rb, 1'b1);
        idle($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 20));
      end
    end
    idle(100);
    chk("sb_drained", exp_q.size(), 32'd0);

    report();
    $finish;
  end
endmodule
